// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sampler.
// Sample rate is derived from the 60 MHz PLL clock (27 MHz x 20 / 9) by integer division.
package acq_pkg;
   localparam int PLL_CLK_HZ    = 60_000_000;
   localparam int DEF_DATA_W    = 12;
   localparam int DEF_ADDR_W    = 14;
   localparam int DEF_DIV       = 6;
   localparam int DEF_SAMPLE_HZ = PLL_CLK_HZ / DEF_DIV;
   localparam int DIV_CNT_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_TRIG,
      ST_DONE
   } acq_state_t;
endpackage

// File: rtl/sample_tick_gen.sv
// Divide-by-DIV sample tick: one-cycle tick when the count is DIV-1; counter restarts from 0 while clear is high.
// Latency: first tick DIV-1 cycles after clear drops; no backpressure, free-running.
module sample_tick_gen
   import acq_pkg::*;
#(
   parameter int DIV = DEF_DIV
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(DIV - 1);

   logic [DIV_CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST) && !clear;
endmodule

// File: rtl/acq_sample_ctrl.sv
// ADC sampler: strobes the ADC every DIV clocks and streams samples into a circular pre/post-trigger buffer.
// Latency: write one cycle after each strobe; no backpressure, the buffer always accepts.
module acq_sample_ctrl
   import acq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DIV    = DEF_DIV
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [ADDR_W-1:0] post_len,
   input  logic [DATA_W-1:0] adc_data,
   output logic              adc_strobe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr
);
   acq_state_t        state, state_nxt;
   logic              active;
   logic              tick;
   logic              tick_clear;
   logic              trig_q;
   logic              trig_edge;
   logic              accept;
   logic              restart;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] post_cnt;

   assign active     = (state == ST_ARMED) || (state == ST_TRIG);
   assign restart    = arm && !abort;
   // A restart or abort also restarts the divider so the first strobe lands DIV cycles after arm.
   assign tick_clear = !active || arm || abort;

   sample_tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .tick  (tick)
   );

   assign adc_strobe = tick;
   assign trig_edge  = trig && !trig_q;
   assign accept     = (state == ST_ARMED) && trig_edge && (pre_cnt >= pre_len) && !arm && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort)
         state_nxt = ST_IDLE;
      else if (arm)
         state_nxt = ST_ARMED;
      else begin
         case (state)
            ST_ARMED: if (accept) state_nxt = ST_TRIG;
            ST_TRIG:  if (mem_we && post_cnt == ADDR_W'(1)) state_nxt = ST_DONE;
            default:  state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_q    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wr_ptr    <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         trig_addr <= '0;
      end else begin
         trig_q <= trig;
         mem_we <= tick;
         if (tick) begin
            mem_addr  <= wr_ptr;
            mem_wdata <= adc_data;
            wr_ptr    <= wr_ptr + 1'b1;
            if (state == ST_ARMED && pre_cnt != '1)
               pre_cnt <= pre_cnt + 1'b1;
         end
         if (restart) begin
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            trig_addr <= '0;
         end
         // Post count is consumed by writes, so a strobe in the accept cycle is the trigger sample.
         if (accept) begin
            trig_addr <= wr_ptr;
            post_cnt  <= (post_len == '0) ? ADDR_W'(1) : post_len;
         end else if (state == ST_TRIG && mem_we && post_cnt != '0) begin
            post_cnt <= post_cnt - 1'b1;
         end
      end
   end

   assign busy = active;
   assign done = (state == ST_DONE);
endmodule
